// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell evaluated per clock, carry kept
// in a flip-flop between bits, registered result with a one-cycle done pulse.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, s_sr_q;
  logic             c_q;
  logic [CW-1:0]    cnt_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;

  logic             s_d, co_d, last_bit;
  logic [WIDTH-1:0] s_sr_d;
  logic             unused_s_lsb;

  // Full-adder cell; the carry is the true majority, not an OR of the inputs.
  assign s_d      = a_sr_q[0] ^ b_sr_q[0] ^ c_q;
  assign co_d     = (a_sr_q[0] & b_sr_q[0]) | (c_q & (a_sr_q[0] ^ b_sr_q[0]));
  assign s_sr_d   = {s_d, s_sr_q[WIDTH-1:1]};
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // The accumulator LSB is always shifted out before it could be observed.
  assign unused_s_lsb = s_sr_q[0];

  // NOTE: all state here is updated with <= so every register samples the
  // values from before the edge; mixing in = would make results order-dependent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sr_q  <= a_in;
            b_sr_q  <= b_in;
            c_q     <= cin;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_sr_q <= {1'b0, a_sr_q[WIDTH-1:1]};
          b_sr_q <= {1'b0, b_sr_q[WIDTH-1:1]};
          s_sr_q <= s_sr_d;
          c_q    <= co_d;
          cnt_q  <= cnt_q + CW'(1);
          if (last_bit) begin
            sum_q   <= s_sr_d;
            carry_q <= co_d;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = done_q;
  assign sum_out   = sum_q;
  assign carry_out = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for carry, busy, back-to-back
// and reset scenarios, and a 4-bit instance swept over every operand combination.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, carry8;
  logic [7:0] sum8;

  logic       start4 = 1'b0, cin4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, carry4;
  logic [3:0] sum4;

  int checks = 0;
  int errors = 0;
  int done4_cnt = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a_in(a8), .b_in(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum_out(sum8), .carry_out(carry8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a_in(a4), .b_in(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum_out(sum4), .carry_out(carry4)
  );

  always @(negedge clk) if (done4 === 1'b1) done4_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns at the negedge following the accepting edge E0.
  task automatic start_8(input logic [7:0] a, input logic [7:0] b, input logic c);
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic wait_done_8(output int n);
    n = 0;
    while (done8 !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("done8_timeout", 32'(n), 32'd8);
  endtask

  task automatic run_8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic [7:0] exp_s, input logic exp_c);
    int n;
    start_8(a, b, c);
    wait_done_8(n);
    check({tag, "_latency"}, 32'(n), 32'd8);
    check({tag, "_sum"}, 32'(sum8), 32'(exp_s));
    check({tag, "_carry"}, 32'(carry8), 32'(exp_c));
    @(negedge clk);
    check({tag, "_done_1cyc"}, 32'(done8), 32'd0);
  endtask

  initial begin
    int busy_first, done_n, first_idx, second_idx, n;
    bit hold_ok;

    #1;
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_sum", 32'(sum8), 32'd0);
    check("rst_carry", 32'(carry8), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_8("0f_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
    run_8("01_01", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);
    run_8("00_01", 8'h00, 8'h01, 1'b0, 8'h01, 1'b0);
    run_8("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_8("ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // Busy protection followed by a back-to-back start in the done cycle.
    start_8(8'h05, 8'h03, 1'b0);
    busy_first = 0; done_n = 0; first_idx = -1; second_idx = -1; hold_ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      start8 = 1'b0;
      if (done_n == 0 && busy8 === 1'b1) busy_first++;
      if (done8 === 1'b1) begin
        done_n++;
        if (done_n == 1) begin
          first_idx = i;
          a8 = 8'h10; b8 = 8'h20; cin8 = 1'b1; start8 = 1'b1;
        end else if (done_n == 2) begin
          second_idx = i;
          check("b2b_sum", 32'(sum8), 32'h31);
          check("b2b_carry", 32'(carry8), 32'd0);
        end
      end else if (done_n == 1 && sum8 !== 8'h08) begin
        hold_ok = 1'b0;
      end
      if (done_n == 1 && i == first_idx) check("prot_sum", 32'(sum8), 32'h08);
      if (i == 2) begin
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
      end
      @(negedge clk);
    end
    start8 = 1'b0;
    check("prot_busy_cycles", 32'(busy_first), 32'd8);
    check("prot_first_done_idx", 32'(first_idx), 32'd8);
    check("b2b_done_count", 32'(done_n), 32'd2);
    check("b2b_spacing", 32'(second_idx - first_idx), 32'd9);
    check("b2b_sum_hold", 32'(hold_ok), 32'd1);

    // Asynchronous reset in the middle of a run.
    start_8(8'h7F, 8'h01, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy8), 32'd0);
    check("arst_done", 32'(done8), 32'd0);
    check("arst_sum", 32'(sum8), 32'd0);
    check("arst_carry", 32'(carry8), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    done_n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 === 1'b1 || busy8 === 1'b1) done_n++;
    end
    check("arst_no_done", 32'(done_n), 32'd0);
    run_8("post_rst", 8'h02, 8'h03, 1'b0, 8'h05, 1'b0);

    // Exhaustive 4-bit sweep.
    done4_cnt = 0;
    for (int v = 0; v < 512; v++) begin
      logic [8:0] vv;
      logic [4:0] exp;
      vv = 9'(v);
      @(negedge clk);
      a4 = vv[3:0]; b4 = vv[7:4]; cin4 = vv[8]; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      n = 0;
      while (done4 !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      exp = 5'(vv[3:0]) + 5'(vv[7:4]) + 5'(vv[8]);
      if (n >= 20) check("sweep_timeout", 32'(n), 32'd4);
      check($sformatf("sweep_%0h_%0h_%0d", vv[3:0], vv[7:4], vv[8]),
            32'({carry4, sum4}), 32'(exp));
    end
    @(negedge clk);
    #1;
    check("sweep_done_pulses", 32'(done4_cnt), 32'd512);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
